program_memory_loadable: RTL and testbench

PROGRAM_MEMORY_LOADABLE -- requirements
Module: program_memory_loadable

---
 rtl/program_memory_loadable.sv | 152 +++++++++++++++
 tb/tb_program_memory_loadable.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/program_memory_loadable.sv
// Loadable instruction memory: single-cycle registered fetch port plus a
// serial byte loader that assembles little-endian words into the array.
//
// Ports:
//   clk, reset         clock, asynchronous active-low reset
//   Address, FetchReq  fetch byte address and request
//   Instruction        registered fetched word (0 on a faulting fetch)
//   InstrValid         one-cycle pulse marking a fetch response
//   AddrFault          qualifies InstrValid: misaligned or out-of-range fetch
//   LoadEnable         level, enters and holds load mode
//   LoadByte/LoadValid serial program byte stream
//   Busy               high while loading
//   LoadDone           one-cycle pulse on leaving the load state
//   LoadCount          words written by the last/current load
module program_memory_loadable #(
  parameter int unsigned           MEMORY_DEPTH = 64,
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = 32'h0040_0000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         Address,
  input  logic                          FetchReq,
  output logic [DATA_WIDTH-1:0]         Instruction,
  output logic                          InstrValid,
  output logic                          AddrFault,
  input  logic                          LoadEnable,
  input  logic [7:0]                    LoadByte,
  input  logic                          LoadValid,
  output logic                          Busy,
  output logic                          LoadDone,
  output logic [$clog2(MEMORY_DEPTH):0] LoadCount
);

  localparam int unsigned AW = $clog2(MEMORY_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {
    IDLE    = 1'b0,
    LOADING = 1'b1
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];
  logic [AW-1:0]         ptr;
  logic [1:0]            lane;
  logic [23:0]           byte_buf;
  // Set when a load filled the array; blocks re-entry until LoadEnable drops.
  logic                  full_hold;

  // Fetch address decode
  logic [DATA_WIDTH-1:0] offset;
  logic [AW-1:0]         index;
  logic                  misaligned;
  logic                  in_range;
  logic                  fault;

  assign offset     = Address - BASE_ADDRESS;
  assign index      = offset[AW+1:2];
  assign misaligned = |Address[1:0];
  assign in_range   = (Address >= BASE_ADDRESS) && (offset[DATA_WIDTH-1:AW+2] == '0);
  assign fault      = misaligned || !in_range;

  // Word write fires when the fourth byte of a word is accepted
  logic        wr_en;
  logic [31:0] wr_word;

  assign wr_en   = (state == LOADING) && LoadEnable && LoadValid && (lane == 2'd3);
  assign wr_word = {LoadByte, byte_buf};

  // Memory array, never reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[ptr] <= DATA_WIDTH'(wr_word);
    end
  end

  // Control FSM and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      Instruction <= '0;
      InstrValid  <= 1'b0;
      AddrFault   <= 1'b0;
      Busy        <= 1'b0;
      LoadDone    <= 1'b0;
      LoadCount   <= '0;
      ptr         <= '0;
      lane        <= '0;
      byte_buf    <= '0;
      full_hold   <= 1'b0;
    end else begin
      InstrValid <= 1'b0;
      AddrFault  <= 1'b0;
      LoadDone   <= 1'b0;
      case (state)
        IDLE: begin
          if (!LoadEnable) begin
            full_hold <= 1'b0;
          end
          if (LoadEnable) begin
            // Load wins over a simultaneous fetch, which is dropped
            if (!full_hold) begin
              state     <= LOADING;
              Busy      <= 1'b1;
              ptr       <= '0;
              lane      <= '0;
              LoadCount <= '0;
            end
          end else if (FetchReq) begin
            InstrValid <= 1'b1;
            if (fault) begin
              AddrFault   <= 1'b1;
              Instruction <= '0;
            end else begin
              Instruction <= mem[index];
            end
          end
        end
        LOADING: begin
          if (!LoadEnable) begin
            // Partial word is discarded
            state    <= IDLE;
            Busy     <= 1'b0;
            LoadDone <= 1'b1;
            lane     <= '0;
          end else if (LoadValid) begin
            if (lane == 2'd3) begin
              lane      <= '0;
              ptr       <= ptr + AW'(1);
              LoadCount <= LoadCount + CW'(1);
              if (LoadCount == CW'(MEMORY_DEPTH - 1)) begin
                state     <= IDLE;
                Busy      <= 1'b0;
                LoadDone  <= 1'b1;
                full_hold <= 1'b1;
              end
            end else begin
              byte_buf[{lane, 3'b000} +: 8] <= LoadByte;
              lane                          <= lane + 2'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_memory_loadable.sv
// Randomized self-checking bench for program_memory_loadable against a
// word-array reference model built from the byte stream.
module tb_program_memory_loadable;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0040_0000;

  logic        clk;
  logic        reset;
  logic [31:0] Address;
  logic        FetchReq;
  logic [31:0] Instruction;
  logic        InstrValid;
  logic        AddrFault;
  logic        LoadEnable;
  logic [7:0]  LoadByte;
  logic        LoadValid;
  logic        Busy;
  logic        LoadDone;
  logic [6:0]  LoadCount;

  int errors = 0;
  int checks = 0;

  logic [31:0] ref_mem   [DEPTH];
  bit          ref_known [DEPTH];

  program_memory_loadable #(
    .MEMORY_DEPTH(DEPTH),
    .DATA_WIDTH  (32),
    .BASE_ADDRESS(BASE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .Address    (Address),
    .FetchReq   (FetchReq),
    .Instruction(Instruction),
    .InstrValid (InstrValid),
    .AddrFault  (AddrFault),
    .LoadEnable (LoadEnable),
    .LoadByte   (LoadByte),
    .LoadValid  (LoadValid),
    .Busy       (Busy),
    .LoadDone   (LoadDone),
    .LoadCount  (LoadCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams bytes with LoadEnable held, then drops LoadEnable.
  task automatic run_load(input logic [7:0] bytes[$], input bit gaps);
    int done_seen;
    int n;
    int exp_words;
    done_seen = 0;
    n         = bytes.size();
    FetchReq   = 1'b0;
    LoadValid  = 1'b0;
    LoadEnable = 1'b1;
    tick();
    check("load_enter_busy", Busy, 1);
    check("load_enter_count", LoadCount, 0);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        while ($urandom_range(3) == 0) begin
          LoadValid = 1'b0;
          FetchReq  = 1'($urandom_range(1));
          Address   = BASE;
          tick();
          done_seen += int'(LoadDone);
        end
      end
      LoadByte  = bytes[i];
      LoadValid = 1'b1;
      FetchReq  = 1'($urandom_range(1));
      Address   = BASE + 32'(4 * $urandom_range(DEPTH - 1));
      tick();
      done_seen += int'(LoadDone);
      check("load_no_fetch", InstrValid, 0);
      if ((i % 4 == 3) && (i / 4 < DEPTH)) begin
        ref_mem[i/4]   = {bytes[i], bytes[i-1], bytes[i-2], bytes[i-3]};
        ref_known[i/4] = 1'b1;
      end
      check("load_busy", Busy, ((i + 1) / 4 < DEPTH) ? 1 : 0);
    end
    LoadValid  = 1'b0;
    FetchReq   = 1'b0;
    LoadEnable = 1'b0;
    tick();
    done_seen += int'(LoadDone);
    tick();
    check("load_done_width", LoadDone, 0);
    exp_words = (n / 4 < DEPTH) ? n / 4 : DEPTH;
    check("load_done_pulses", 32'(done_seen), 1);
    check("load_count", LoadCount, 32'(exp_words));
    check("load_idle_busy", Busy, 0);
  endtask

  // Single fetch followed by an idle cycle that must hold Instruction.
  task automatic do_fetch(input string tag, input logic [31:0] addr);
    longint off;
    bit     flt;
    bit     known;
    logic [31:0] exp;
    off   = longint'(addr) - longint'(BASE);
    flt   = (addr % 4 != 0) || (off < 0) || (off / 4 >= longint'(DEPTH));
    known = 1'b1;
    exp   = 32'h0;
    if (!flt) begin
      known = ref_known[int'(off / 4)];
      exp   = ref_mem[int'(off / 4)];
    end
    Address    = addr;
    FetchReq   = 1'b1;
    LoadEnable = 1'b0;
    tick();
    FetchReq = 1'b0;
    check({tag, "_valid"}, InstrValid, 1);
    check({tag, "_fault"}, AddrFault, 32'(flt));
    if (known) check({tag, "_data"}, Instruction, exp);
    tick();
    check({tag, "_idle_valid"}, InstrValid, 0);
    check({tag, "_idle_fault"}, AddrFault, 0);
    if (known) check({tag, "_hold"}, Instruction, exp);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [31:0] a;
    for (int i = 0; i < DEPTH; i++) ref_known[i] = 1'b0;
    reset      = 1'b0;
    Address    = '0;
    FetchReq   = 1'b0;
    LoadEnable = 1'b0;
    LoadByte   = '0;
    LoadValid  = 1'b0;
    tick();
    tick();
    check("rst_instr", Instruction, 0);
    check("rst_valid", InstrValid, 0);
    check("rst_fault", AddrFault, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", LoadDone, 0);
    check("rst_count", LoadCount, 0);
    reset = 1'b1;
    tick();

    // Eight-byte little-endian load
    q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load(q, 1'b0);
    check("model_w0", ref_mem[0], 32'h1234_5678);
    check("model_w1", ref_mem[1], 32'hDEAD_BEEF);
    do_fetch("fetch_w1", 32'h0040_0004);
    do_fetch("fetch_w0", 32'h0040_0000);

    // Faulting fetches
    do_fetch("misaligned", 32'h0040_0002);
    do_fetch("above_range", 32'h0040_0100);
    do_fetch("below_base", 32'h003F_FFFC);
    do_fetch("top_addr", 32'hFFFF_FFFC);

    // Full load with surplus bytes and random gaps
    q.delete();
    for (int i = 0; i < 4 * DEPTH + 3; i++) q.push_back(8'($urandom));
    run_load(q, 1'b1);
    do_fetch("full_first", BASE);
    do_fetch("full_last", BASE + 32'(4 * (DEPTH - 1)));

    // Random fetch mix
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(4))
        0, 1:    a = BASE + 32'(4 * $urandom_range(DEPTH - 1));
        2:       a = BASE + 32'(4 * $urandom_range(DEPTH - 1)) + 32'($urandom_range(3, 1));
        3:       a = BASE - 32'(4 * $urandom_range(64, 1));
        default: a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(1000));
      endcase
      do_fetch("rand_fetch", a);
    end

    // Load dropped mid-word: second word must stay unchanged
    q.delete();
    for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
    run_load(q, 1'b1);
    do_fetch("partial_w0", BASE);
    do_fetch("partial_w1", BASE + 32'd4);

    // Reset during a load after six bytes
    LoadEnable = 1'b1;
    LoadValid  = 1'b0;
    tick();
    q.delete();
    for (int i = 0; i < 6; i++) begin
      q.push_back(8'($urandom));
      LoadByte  = q[i];
      LoadValid = 1'b1;
      tick();
    end
    ref_mem[0] = {q[3], q[2], q[1], q[0]};
    check("pre_rst_count", LoadCount, 1);
    #2 reset = 1'b0;
    #1;
    check("abort_instr", Instruction, 0);
    check("abort_busy", Busy, 0);
    check("abort_count", LoadCount, 0);
    check("abort_done", LoadDone, 0);
    LoadEnable = 1'b0;
    LoadValid  = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    do_fetch("abort_w0", BASE);
    do_fetch("abort_w1", BASE + 32'd4);

    // Fetch and load requested together: load wins
    Address    = BASE;
    FetchReq   = 1'b1;
    LoadEnable = 1'b1;
    tick();
    check("collide_busy", Busy, 1);
    check("collide_valid", InstrValid, 0);
    FetchReq   = 1'b0;
    LoadEnable = 1'b0;
    tick();
    check("collide_done", LoadDone, 1);
    check("collide_count", LoadCount, 0);
    check("collide_idle", Busy, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
